// File: rtl/command_transmitter.sv
// Serialises (command, param) pairs into a byte stream: command byte, then optional LSB-first param bytes.
// Define COMMAND_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module command_transmitter #(
  parameter int unsigned PARAM_BYTES    = 4,
  parameter int unsigned PARAM_FLAG_BIT = 7,
  parameter int unsigned QUEUE_DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               command,
  input  logic [8*PARAM_BYTES-1:0] param,
  input  logic                     command_valid,
  output logic                     command_ready,
  output logic [7:0]               serial_output_data,
  output logic                     serial_output_valid,
  input  logic                     serial_output_ready,
  output logic                     busy
);

  localparam int unsigned PW    = 8 * PARAM_BYTES;
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned IDX_W = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;

`ifdef COMMAND_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, CMD, PARAM, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, CMD, PARAM} state_t;
`endif

  logic [7:0]       q_cmd   [QUEUE_DEPTH];
  logic [PW-1:0]    q_param [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             push, pop, nonempty;
  logic [7:0]       head_cmd;
  logic [PW-1:0]    head_param;

  state_t           state, state_n;
  logic [7:0]       data_n;
  logic             valid_n;
  logic [PW-1:0]    param_sh, sh_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             xfer, last_byte, frame_end, load;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push       = command_valid && command_ready;
  assign nonempty   = (count != '0);
  assign head_cmd   = q_cmd[rd_ptr];
  assign head_param = q_param[rd_ptr];
  assign xfer       = serial_output_valid && serial_output_ready;
  assign busy       = (state != IDLE) || nonempty;

  always_comb count_n = count + CNT_W'(push) - CNT_W'(pop);

  // Ready is registered from the post-edge occupancy, so a same-cycle pop never admits a push into a full queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      command_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count         <= count_n;
      command_ready <= (count_n != CNT_W'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_cmd[wr_ptr]   <= command;
      q_param[wr_ptr] <= param;
    end
  end

`ifdef COMMAND_TX_CHECKSUM_EN
  logic [7:0] acc;

  // Accumulates every byte as it is loaded into the output register; cleared by the command load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           acc <= '0;
    else if (load)                       acc <= head_cmd;
    else if (xfer && state_n == PARAM)   acc <= acc ^ data_n;
  end
`endif

  always_comb begin
    state_n   = state;
    data_n    = serial_output_data;
    valid_n   = serial_output_valid;
    sh_n      = param_sh;
    idx_n     = idx;
    pop       = 1'b0;
    last_byte = 1'b0;
    frame_end = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: load = nonempty;
      CMD: begin
        if (xfer) begin
          if (serial_output_data[PARAM_FLAG_BIT]) begin
            state_n = PARAM;
            idx_n   = '0;
            data_n  = param_sh[7:0];
            sh_n    = param_sh >> 8;
          end else begin
            last_byte = 1'b1;
          end
        end
      end
      PARAM: begin
        if (xfer) begin
          if (idx != IDX_W'(PARAM_BYTES - 1)) begin
            idx_n  = idx + 1'b1;
            data_n = param_sh[7:0];
            sh_n   = param_sh >> 8;
          end else begin
            last_byte = 1'b1;
          end
        end
      end
`ifdef COMMAND_TX_CHECKSUM_EN
      CSUM: if (xfer) frame_end = 1'b1;
`endif
      default: state_n = IDLE;
    endcase

    if (last_byte) begin
`ifdef COMMAND_TX_CHECKSUM_EN
      state_n = CSUM;
      data_n  = acc;
`else
      frame_end = 1'b1;
`endif
    end

    // Chaining the next frame on the final transfer keeps back-to-back frames gap-free.
    if (frame_end) begin
      if (nonempty) begin
        load = 1'b1;
      end else begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    end

    if (load) begin
      pop     = 1'b1;
      state_n = CMD;
      data_n  = head_cmd;
      valid_n = 1'b1;
      sh_n    = head_param;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      serial_output_data  <= '0;
      serial_output_valid <= 1'b0;
      param_sh            <= '0;
      idx                 <= '0;
    end else begin
      state               <= state_n;
      serial_output_data  <= data_n;
      serial_output_valid <= valid_n;
      param_sh            <= sh_n;
      idx                 <= idx_n;
    end
  end

endmodule

// File: tb/tb_command_transmitter.sv
// Directed self-checking bench for command_transmitter; expected byte streams are built from the inputs,
// including the checksum byte when COMMAND_TX_CHECKSUM_EN is defined.
module tb_command_transmitter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  command = '0;
  logic [31:0] param = '0;
  logic        command_valid = 1'b0;
  logic        command_ready;
  logic [7:0]  serial_output_data;
  logic        serial_output_valid;
  logic        serial_output_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt  = 0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];

  command_transmitter #(
    .PARAM_BYTES   (4),
    .PARAM_FLAG_BIT(7),
    .QUEUE_DEPTH   (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .command            (command),
    .param              (param),
    .command_valid      (command_valid),
    .command_ready      (command_ready),
    .serial_output_data (serial_output_data),
    .serial_output_valid(serial_output_valid),
    .serial_output_ready(serial_output_ready),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Inputs only change 1ns after a rising edge, so the negedge view is what the next edge transfers.
  always @(negedge clock) begin
    if (!reset && serial_output_valid) begin
      vcnt <= vcnt + 1;
      if (serial_output_ready) begin
        rx_q.push_back(serial_output_data);
        rx_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_streams;
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
    vcnt = 0;
  endtask

  task automatic expect_frame(input logic [7:0] c, input logic [31:0] p);
    logic [7:0] x;
    logic [7:0] b;
    x = c;
    exp_q.push_back(c);
    if (c[7]) begin
      for (int i = 0; i < 4; i++) begin
        b = p[8*i +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef COMMAND_TX_CHECKSUM_EN
    exp_q.push_back(x);
`else
    if (x === 8'hxx) exp_q.push_back(x);
`endif
  endtask

  task automatic push_cmd(input logic [7:0] c, input logic [31:0] p);
    int n;
    n = 0;
    command       = c;
    param         = p;
    command_valid = 1'b1;
    while (!command_ready && n < 50) begin
      tick;
      n++;
    end
    total++;
    if (!command_ready) begin
      bad++;
      $display("FAIL push_wait actual command_ready=%0b required 1", command_ready);
    end
    tick;
    command_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || serial_output_valid) && n < 300) begin
      tick;
      n++;
    end
    total++;
    if (busy || serial_output_valid) begin
      bad++;
      $display("FAIL %s_idle actual busy=%0b valid=%0b required 0 0", name, busy, serial_output_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    total++; if (serial_output_valid !== 1'b0) begin bad++; $display("FAIL rst_valid actual=%0b required=0", serial_output_valid); end
    total++; if (serial_output_data !== 8'h00) begin bad++; $display("FAIL rst_data actual=%02h required=00", serial_output_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy actual=%0b required=0", busy); end
    total++; if (command_ready !== 1'b1) begin bad++; $display("FAIL rst_ready actual=%0b required=1", command_ready); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    clear_streams();
    serial_output_ready = 1'b1;
    expect_frame(8'h03, 32'h0);
    push_cmd(8'h03, 32'hFFFF_FFFF);
    total++; if (serial_output_valid !== 1'b0) begin bad++; $display("FAIL single_lat_early actual valid=%0b required=0", serial_output_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy actual=%0b required=1", busy); end
    tick;
    total++; if (serial_output_valid !== 1'b1 || serial_output_data !== 8'h03) begin
      bad++; $display("FAIL single_first actual valid=%0b data=%02h required 1 03", serial_output_valid, serial_output_data);
    end
    wait_idle("single");
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL single_len actual=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d actual=%02h required=%02h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (vcnt != exp_q.size()) begin bad++; $display("FAIL single_valid_cycles actual=%0d required=%0d", vcnt, exp_q.size()); end
  endtask

  task automatic test_param_frame;
    clear_streams();
    serial_output_ready = 1'b1;
    expect_frame(8'h84, 32'h0403_0201);
    push_cmd(8'h84, 32'h0403_0201);
    param = 32'hDEAD_BEEF;
    wait_idle("param");
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL param_len actual=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL param_byte%0d actual=%02h required=%02h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      total++; if (rx_cyc[i] != rx_cyc[i-1] + 1) begin bad++; $display("FAIL param_gap%0d actual=%0d required=%0d", i, rx_cyc[i], rx_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    clear_streams();
    serial_output_ready = 1'b1;
    expect_frame(8'h84, 32'h0403_0201);
    push_cmd(8'h84, 32'h0403_0201);
    n = 0;
    while (!(serial_output_valid && serial_output_data == 8'h02) && n < 20) begin
      tick;
      n++;
    end
    total++; if (!(serial_output_valid && serial_output_data == 8'h02)) begin
      bad++; $display("FAIL bp_reach actual data=%02h required=02", serial_output_data);
    end
    serial_output_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (serial_output_valid !== 1'b1 || serial_output_data !== 8'h02) begin
        bad++; $display("FAIL bp_hold%0d actual valid=%0b data=%02h required 1 02", k, serial_output_valid, serial_output_data);
      end
    end
    serial_output_ready = 1'b1;
    wait_idle("bp");
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_len actual=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d actual=%02h required=%02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_queue_full;
    clear_streams();
    serial_output_ready = 1'b0;
    expect_frame(8'h11, 32'h0);
    expect_frame(8'h85, 32'hDDCC_BBAA);
    expect_frame(8'h22, 32'h0);
    expect_frame(8'h86, 32'h0F0E_0D0C);
    // First entry moves to the output register, so two more fill the queue.
    push_cmd(8'h11, 32'h0);
    total++; if (command_ready !== 1'b1) begin bad++; $display("FAIL full_rdy1 actual=%0b required=1", command_ready); end
    push_cmd(8'h85, 32'hDDCC_BBAA);
    total++; if (command_ready !== 1'b1) begin bad++; $display("FAIL full_rdy2 actual=%0b required=1", command_ready); end
    push_cmd(8'h22, 32'h1234_5678);
    total++; if (command_ready !== 1'b0) begin bad++; $display("FAIL full_rdy3 actual=%0b required=0", command_ready); end
    command       = 8'h86;
    param         = 32'h0F0E_0D0C;
    command_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (command_ready !== 1'b0) begin bad++; $display("FAIL full_held%0d actual ready=%0b required=0", k, command_ready); end
      total++; if (serial_output_valid !== 1'b1 || serial_output_data !== 8'h11) begin
        bad++; $display("FAIL full_out%0d actual valid=%0b data=%02h required 1 11", k, serial_output_valid, serial_output_data);
      end
    end
    serial_output_ready = 1'b1;
    push_cmd(8'h86, 32'h0F0E_0D0C);
    wait_idle("full");
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL full_len actual=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_byte%0d actual=%02h required=%02h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      total++; if (rx_cyc[i] != rx_cyc[i-1] + 1) begin bad++; $display("FAIL full_gap%0d actual=%0d required=%0d", i, rx_cyc[i], rx_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    clear_streams();
    serial_output_ready = 1'b1;
    push_cmd(8'h84, 32'h0403_0201);
    push_cmd(8'h55, 32'h0);
    n = 0;
    while (!(serial_output_valid && serial_output_data == 8'h02) && n < 20) begin
      tick;
      n++;
    end
    total++; if (!(serial_output_valid && serial_output_data == 8'h02)) begin
      bad++; $display("FAIL mid_reach actual data=%02h required=02", serial_output_data);
    end
    reset = 1'b1;
    #1;
    total++; if (serial_output_valid !== 1'b0) begin bad++; $display("FAIL mid_valid actual=%0b required=0", serial_output_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy actual=%0b required=0", busy); end
    total++; if (command_ready !== 1'b1) begin bad++; $display("FAIL mid_ready actual=%0b required=1", command_ready); end
    tick;
    reset = 1'b0;
    tick;
    clear_streams();
    expect_frame(8'h03, 32'h0);
    push_cmd(8'h03, 32'h0);
    wait_idle("mid");
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_len actual=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_byte%0d actual=%02h required=%02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_param_frame();
    test_backpressure();
    test_queue_full();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
